// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, default word width and a width helper for the layer sequencing blocks
package nn_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;
  localparam int DATA_WIDTH_DEF = 16;
  function automatic int clog2_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: counts enabled cycles and flags the LIMIT-th one
module seq_timeout_counter import nn_pkg::*; #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = clog2_w(LIMIT);
  logic [W-1:0] cnt;
  assign expire = en && (cnt == W'(LIMIT - 1));
  // cycle counter, restarted by load and frozen once it expires
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: clears a neuron layer, streams one frame of features into it and captures its output
module layer_sequencer import nn_pkg::*; #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 128,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FEAT_AW     = 10,
  parameter int TIMEOUT     = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              feat_rd_en,
  output logic [FEAT_AW-1:0]                feat_rd_addr,
  input  logic [DATA_WIDTH-1:0]             feat_rd_data,
  output logic                              layer_clr,
  output logic [31:0]                       local_addr,
  output logic [DATA_WIDTH-1:0]             data_in,
  output logic                              input_valid,
  input  logic [NUM_NEURONS-1:0]            out_valids,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] result,
  output logic                              result_valid
);
  seq_state_t state, state_nx;
  logic [FEAT_AW-1:0] addr_cnt;
  logic accept, last, capture, expire;
  assign accept  = (state == IDLE) && start;
  assign last    = addr_cnt == FEAT_AW'(NUM_INPUTS - 1);
  assign capture = (state == WAIT) && (&out_valids) && !input_valid;
  assign data_in = feat_rd_data;
  seq_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .en     (state == WAIT),
    .expire (expire)
  );
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state: a capture or timeout both end the frame
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CLEAR : IDLE;
      CLEAR:   state_nx = FEED;
      FEED:    state_nx = last ? WAIT : FEED;
      default: state_nx = (capture || expire) ? IDLE : WAIT;
    endcase
  end
  // state-decoded outputs; addresses read as zero outside FEED
  always_comb begin
    busy         = state != IDLE;
    layer_clr    = state == CLEAR;
    feat_rd_en   = state == FEED;
    feat_rd_addr = feat_rd_en ? addr_cnt : '0;
    local_addr   = feat_rd_en ? 32'(addr_cnt) : '0;
  end
  // feature/weight address counter, runs only while feeding
  always_ff @(posedge clk or negedge rst)
    if (!rst) addr_cnt <= '0;
    else addr_cnt <= (state == FEED && !last) ? addr_cnt + 1'b1 : '0;
  // input qualifier, result capture and status flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      input_valid  <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      input_valid <= feat_rd_en;
      done        <= capture;
      if (accept) begin
        error        <= 1'b0;
        result_valid <= 1'b0;
      end else if (capture) begin
        result       <= layer_out;
        result_valid <= 1'b1;
      end else if (expire) error <= 1'b1;
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for the layer sequencer with a small feature memory and neuron model
module tb_layer_sequencer;
  logic clk = 0, rst = 0, start = 0;
  logic busy, done, error, feat_rd_en, layer_clr, input_valid, result_valid;
  logic [9:0] feat_rd_addr;
  logic [15:0] feat_rd_data = '0, data_in, feat_base = 16'd1;
  logic [31:0] local_addr, layer_out, result;
  logic [1:0] out_valids, mask = 2'b11;
  logic ovr = 0;
  logic [15:0] acc0 = '0, acc1 = '0;
  int ncnt = 0;
  logic p1 = 0, vflag = 0;
  int cyc = 0, s0 = 0, s1 = 0, errors = 0, checks = 0;
  typedef struct {int cyc; logic [63:0] v;} exp_t;
  exp_t qc[$], qa[$], qi[$], qd[$];

  layer_sequencer #(.NUM_INPUTS(4), .NUM_NEURONS(2), .DATA_WIDTH(16), .FEAT_AW(10), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
    .layer_clr(layer_clr), .local_addr(local_addr), .data_in(data_in), .input_valid(input_valid),
    .out_valids(out_valids), .layer_out(layer_out), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (feat_rd_en) feat_rd_data <= feat_base + 16'(feat_rd_addr);

  always @(posedge clk)
    if (layer_clr) begin
      acc0 <= '0; acc1 <= '0; ncnt <= 0; p1 <= 0; vflag <= 0;
    end else begin
      if (input_valid) begin
        acc0 <= acc0 + data_in;
        acc1 <= acc1 + {data_in[14:0], 1'b0};
        ncnt <= ncnt + 1;
      end
      p1 <= input_valid && ncnt == 3;
      if (p1) vflag <= 1;
    end
  assign out_valids = vflag ? mask : 2'b00;
  assign layer_out  = ovr ? 32'hdeadbeef : {acc1, acc0};

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic bad(input string n);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d, none expected", n, cyc);
  endtask

  task automatic rst_chk(input string n);
    chk({n, "_flags"}, 64'({busy, done, error, feat_rd_en, layer_clr, input_valid, result_valid}), 0);
    chk({n, "_addr"}, 64'(feat_rd_addr), 0);
    chk({n, "_local_addr"}, 64'(local_addr), 0);
    chk({n, "_result"}, 64'(result), 0);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go(input logic [15:0] base, input logic [63:0] res, input bit with_done);
    s0 = cyc;
    feat_base = base;
    start = 1;
    qc.push_back('{s0 + 1, 64'd1});
    for (int k = 0; k < 4; k++) begin
      qa.push_back('{s0 + 2 + k, 64'(k)});
      qi.push_back('{s0 + 3 + k, 64'(base) + 64'(k)});
    end
    if (with_done) qd.push_back('{s0 + 9, res});
    @(negedge clk);
    start = 0;
  endtask

  always @(negedge clk)
    if (rst) begin
      exp_t e;
      if (layer_clr) begin
        if (qc.size() == 0) bad("layer_clr_extra");
        else begin e = qc.pop_front(); chk("layer_clr_cyc", 64'(cyc), 64'(e.cyc)); end
      end
      if (feat_rd_en) begin
        if (qa.size() == 0) bad("feat_rd_extra");
        else begin
          e = qa.pop_front();
          chk("feat_rd_cyc", 64'(cyc), 64'(e.cyc));
          chk("feat_rd_addr", 64'(feat_rd_addr), e.v);
          chk("local_addr", 64'(local_addr), e.v);
        end
      end
      if (input_valid) begin
        if (qi.size() == 0) bad("input_valid_extra");
        else begin
          e = qi.pop_front();
          chk("input_valid_cyc", 64'(cyc), 64'(e.cyc));
          chk("data_in", 64'(data_in), e.v);
        end
      end
      if (done) begin
        if (qd.size() == 0) bad("done_extra");
        else begin
          e = qd.pop_front();
          chk("done_cyc", 64'(cyc), 64'(e.cyc));
          chk("result", 64'(result), e.v);
          chk("done_result_valid", 64'(result_valid), 1);
        end
      end
    end

  initial begin
    #1 rst_chk("reset");
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    // basic frame: features 1..4 give sums 10 and 20
    go(16'd1, 64'h0014000a, 1);
    wait_to(s0 + 9);
    chk("f1_busy_after", 64'(busy), 0);
    chk("f1_result_valid", 64'(result_valid), 1);
    wait_to(s0 + 12);
    ovr = 1;
    repeat (3) @(negedge clk);
    chk("hold_result", 64'(result), 64'h0014000a);
    ovr = 0;
    // start while busy and in the cycle WAIT exits is ignored
    go(16'd1, 64'h0014000a, 1);
    wait_to(s0 + 4);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_to(s0 + 8);
    chk("exit_busy", 64'(busy), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("ignored_busy", 64'(busy), 0);
    repeat (4) @(negedge clk);
    // timeout with only one neuron valid
    mask = 2'b01;
    go(16'd1, 0, 0);
    chk("to_rv_cleared", 64'(result_valid), 0);
    wait_to(s0 + 13);
    chk("to_busy_last_wait", 64'(busy), 1);
    chk("to_error_early", 64'(error), 0);
    @(negedge clk);
    chk("to_error", 64'(error), 1);
    chk("to_busy", 64'(busy), 0);
    chk("to_result_valid", 64'(result_valid), 0);
    repeat (3) @(negedge clk);
    mask = 2'b11;
    go(16'd1, 64'h0014000a, 1);
    chk("error_cleared", 64'(error), 0);
    wait_to(s0 + 12);
    // asynchronous reset mid-FEED with addr_cnt at 2
    go(16'd1, 0, 0);
    wait_to(s0 + 4);
    #2 rst = 0;
    #1 rst_chk("midrst");
    qc.delete(); qa.delete(); qi.delete(); qd.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    go(16'd1, 64'h0014000a, 1);
    wait_to(s0 + 12);
    // back-to-back frames, second features 10..13 give sums 46 and 92
    go(16'd1, 64'h0014000a, 1);
    s1 = s0 + 10;
    wait_to(s1);
    chk("b2b_rv_before", 64'(result_valid), 1);
    go(16'd10, 64'h005c002e, 1);
    chk("b2b_rv_dropped", 64'(result_valid), 0);
    wait_to(s1 + 8);
    chk("b2b_rv_low_in_wait", 64'(result_valid), 0);
    wait_to(s1 + 9);
    chk("b2b_rv_raised", 64'(result_valid), 1);
    wait_to(s1 + 12);
    chk("queues_drained", 64'(qc.size() + qa.size() + qi.size() + qd.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Frame-level controller for one fully-connected layer instance (neuron array plus per-neuron weight/bias memories).
- On `start`, clears the neurons and streams NUM_INPUTS features from an external feature memory, driving the shared weight address in lockstep.
- Waits until every neuron reports valid, captures the packed layer output into a result register and signals done.
- Sits between the top-level network scheduler and each layer; one instance per layer.

Parameters:
- NUM_INPUTS, 784, features per frame (weights per neuron)
- NUM_NEURONS, 128, neurons in the sequenced layer
- DATA_WIDTH, 16, feature/output word width
- FEAT_AW, 10, feature-memory address width (must satisfy 2**FEAT_AW >= NUM_INPUTS)
- TIMEOUT, 4096, max cycles in WAIT before error

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin a frame; ignored unless IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when result captured
- error  out  1  sticky timeout flag; cleared by next accepted start or reset
- feat_rd_en  out  1  feature-memory read enable
- feat_rd_addr  out  FEAT_AW  feature-memory address
- feat_rd_data  in  DATA_WIDTH  feature word, valid one cycle after feat_rd_en
- layer_clr  out  1  active-high synchronous clear pulse to the neuron array
- local_addr  out  32  weight-memory address, zero-extended counter
- data_in  out  DATA_WIDTH  feature to neurons (feat_rd_data passthrough)
- input_valid  out  1  qualifies data_in
- out_valids  in  NUM_NEURONS  per-neuron valid from the layer
- layer_out  in  NUM_NEURONS*DATA_WIDTH  packed neuron outputs
- result  out  NUM_NEURONS*DATA_WIDTH  captured layer output
- result_valid  out  1  high from capture until next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0. All outputs 0, including result, result_valid and error.
- States: IDLE, CLEAR, FEED, WAIT.
- IDLE: start=1 -> CLEAR. Also clears error, result_valid and the timeout counter.
- CLEAR: exactly one cycle. layer_clr=1 -> FEED, addr_cnt=0.
- FEED: feat_rd_en=1; feat_rd_addr=addr_cnt; local_addr=addr_cnt.
  - addr_cnt increments every cycle; no stall.
  - When addr_cnt==NUM_INPUTS-1 -> WAIT, addr_cnt=0.
  - local_addr is 0 outside FEED.
- input_valid is feat_rd_en delayed one cycle. This aligns with the 1-cycle read latency of both the feature memory and the weight memories.
  - Result: exactly NUM_INPUTS consecutive input_valid cycles, the last one in the first WAIT cycle.
- data_in = feat_rd_data combinationally.
- WAIT:
  - When &out_valids==1 and input_valid==0: result<=layer_out, result_valid<=1, done pulses the same cycle as the capture register write (visible next cycle), -> IDLE.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT: error<=1, result_valid stays 0, no done, -> IDLE.
- start while busy: ignored, no queuing.
- start in the same cycle WAIT exits: ignored; start must be re-issued from IDLE.
- Frame latency, start accepted at cycle 0:
  - layer_clr at 1
  - feat_rd_en cycles 2..NUM_INPUTS+1
  - input_valid cycles 3..NUM_INPUTS+2
- Reset mid-frame: immediate return to IDLE, all outputs 0. Neurons are not cleared until the next CLEAR.
- out_valids asserted during FEED: ignored; capture only in WAIT.

Decomposition:
- Shared package nn_pkg:
  - state encoding enum (IDLE=0, CLEAR=1, FEED=2, WAIT=3)
  - DATA_WIDTH default
  - address-width helper (clog2)
- One natural sub-module: seq_timeout_counter (load/enable/expire). Everything else lives in layer_sequencer.

Test Plan:
- Basic frame, NUM_INPUTS=4, NUM_NEURONS=2, features 1,2,3,4, neuron model raising both valids 2 cycles after last input_valid -> feat_rd_addr 0,1,2,3 on cycles 2..5; input_valid cycles 3..6 with data_in 1..4; done pulse once; result==layer_out snapshot; result_valid=1.
- Start pulsed at cycle 4 while busy -> no effect; a single frame completes; layer_clr pulses exactly once.
- Only out_valids[0] set in WAIT, TIMEOUT=8 -> error=1 after 8 WAIT cycles, no done, result_valid=0, busy=0; next start clears error.
- rst driven low mid-FEED (addr_cnt=2) -> all outputs 0 asynchronously; after release, new start runs the full 4-address sequence from 0.
- Back-to-back frames with start re-issued the cycle after done -> second frame's layer_clr precedes its first input_valid; result_valid drops at the second start and rises at its capture.
- layer_out changes after capture -> result holds the captured value until the next capture.
